// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, PSR flag bit
// positions, the control FSM states and the iterative datapath modes.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_ASHU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;

  // PSR layout {C,Z,L,F,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SHIFT, ST_MUL} state_e;

  typedef enum logic [1:0] {IT_LSL, IT_LSR, IT_ASR, IT_MUL} it_mode_e;

endpackage

// File: rtl/alu_iterative_unit.sv
// Shared shift / multiply datapath. One step per clock while the iteration
// counter is non-zero.
//   load     : capture mode, operands and step count
//   mode     : IT_LSL/IT_LSR/IT_ASR shift a by one bit per step;
//              IT_MUL shift-add of a*b, one multiplier bit per step
//   amount   : number of steps
//   result   : accumulator (shifted value or low WIDTH product bits)
//   finished : counter is zero, result is final
module alu_iterative_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  it_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    amount,
  output logic [WIDTH-1:0] result,
  output logic             finished
);

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]    cnt_q;
  it_mode_e         mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mode_q   <= IT_LSL;
    end else if (load) begin
      mode_q <= mode;
      cnt_q  <= amount;
      if (mode == IT_MUL) begin
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
      end else begin
        acc_q    <= a;
        mcand_q  <= '0;
        mplier_q <= '0;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      case (mode_q)
        IT_LSL: acc_q <= {acc_q[WIDTH-2:0], 1'b0};
        IT_LSR: acc_q <= {1'b0, acc_q[WIDTH-1:1]};
        IT_ASR: acc_q <= {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        default: begin
          // Product bits above WIDTH are never needed, so the multiplicand
          // is simply shifted left and allowed to fall off the top.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        end
      endcase
    end
  end

  assign result   = acc_q;
  assign finished = (cnt_q == '0);

endmodule

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU with PSR flag merge.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   start, op, a, b    : op request, captured when idle
//   psr_in             : current {C,Z,L,F,N}, captured with start
//   busy               : iterative op (shift/MUL) in progress
//   done               : one-cycle completion pulse
//   result, result_we  : register-file data / write strobe
//   flags_out, flags_we: next PSR value / PSR enable
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       psr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [4:0]       flags_out,
  output logic             flags_we
);

  localparam int MSB = WIDTH - 1;
  // Counter must hold both WIDTH (MUL) and 16 (shift by -16).
  localparam int CW  = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       psr_q;

  // ---------------- single-cycle ALU on latched operands ----------------
  logic [WIDTH:0]   sum, dif;
  logic             cin;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flg;
  logic             alu_rwe, alu_fwe;

  always_comb begin
    alu_res = a_q;
    alu_flg = psr_q;
    alu_rwe = 1'b1;
    alu_fwe = 1'b0;
    cin     = (op_q == OP_ADDC) ? psr_q[FLAG_C] : 1'b0;
    sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        alu_res         = sum[MSB:0];
        alu_fwe         = 1'b1;
        alu_flg[FLAG_C] = sum[WIDTH];
        alu_flg[FLAG_F] = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res         = dif[MSB:0];
        alu_fwe         = 1'b1;
        alu_flg[FLAG_C] = dif[WIDTH];  // borrow out == (a <u b)
        alu_flg[FLAG_F] = (a_q[MSB] != b_q[MSB]) && (dif[MSB] != a_q[MSB]);
      end
      OP_CMP: begin
        alu_rwe         = 1'b0;
        alu_fwe         = 1'b1;
        alu_flg[FLAG_Z] = (a_q == b_q);
        alu_flg[FLAG_L] = (a_q < b_q);
        alu_flg[FLAG_N] = ($signed(a_q) < $signed(b_q));
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_MOV:  alu_res = b_q;
      OP_LUI:  alu_res = WIDTH'({b_q[7:0], a_q[7:0]});
      OP_LSH, OP_ASHU: alu_res = a_q;  // only reaches here with s == 0
      default: alu_rwe = 1'b0;         // NOP
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic [4:0]       s_in, s_abs;
  logic             it_load, it_fin;
  it_mode_e         it_mode;
  logic [CW-1:0]    it_amt;
  logic [WIDTH-1:0] it_res;

  assign s_in  = b[4:0];
  assign s_abs = s_in[4] ? (5'd0 - s_in) : s_in;  // -16 maps to 5'd16

  alu_iterative_unit #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clock   (clock),
    .reset   (reset),
    .load    (it_load),
    .mode    (it_mode),
    .a       (a),
    .b       (b),
    .amount  (it_amt),
    .result  (it_res),
    .finished(it_fin)
  );

  // ---------------- control FSM ----------------
  logic             fin_d, res_we_d, flg_we_d, busy_d;
  logic [WIDTH-1:0] res_d;
  logic [4:0]       flg_d;

  always_comb begin
    state_d  = state_q;
    it_load  = 1'b0;
    it_mode  = IT_LSL;
    it_amt   = '0;
    fin_d    = 1'b0;
    res_we_d = 1'b0;
    flg_we_d = 1'b0;
    res_d    = alu_res;
    flg_d    = alu_flg;
    case (state_q)
      ST_IDLE: if (start) begin
        if (op == OP_MUL) begin
          state_d = ST_MUL;
          it_load = 1'b1;
          it_mode = IT_MUL;
          it_amt  = CW'(WIDTH);
        end else if ((op == OP_LSH || op == OP_ASHU) && s_in != 5'd0) begin
          state_d = ST_SHIFT;
          it_load = 1'b1;
          it_mode = !s_in[4] ? IT_LSL : (op == OP_LSH) ? IT_LSR : IT_ASR;
          it_amt  = CW'(s_abs);
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d  = ST_IDLE;
        fin_d    = 1'b1;
        res_we_d = alu_rwe;
        flg_we_d = alu_fwe;
      end
      default: if (it_fin) begin  // ST_SHIFT, ST_MUL
        state_d  = ST_IDLE;
        fin_d    = 1'b1;
        res_we_d = 1'b1;
        res_d    = it_res;
      end
    endcase
    // busy trails the state by one edge so the accept cycle itself and the
    // done cycle both show busy low.
    busy_d = (state_q == ST_SHIFT || state_q == ST_MUL) &&
             (state_d == ST_SHIFT || state_d == ST_MUL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_we <= 1'b0;
      flags_we  <= 1'b0;
      result    <= '0;
      flags_out <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      psr_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= fin_d;
      result_we <= res_we_d;
      flags_we  <= flg_we_d;
      if (res_we_d) result <= res_d;
      if (fin_d) flags_out <= flg_d;
      if (state_q == ST_IDLE && start) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        psr_q <= psr_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
module tb_alu_flag_unit;
  import alu_pkg::*;

  logic        clock, reset, start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic [4:0]  psr_in;
  logic        busy, done, result_we, flags_we;
  logic [15:0] result;
  logic [4:0]  flags_out;

  alu_flag_unit #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .psr_in(psr_in), .busy(busy), .done(done), .result(result),
    .result_we(result_we), .flags_out(flags_out), .flags_we(flags_we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [4:0]  flg;
    logic        rwe, fwe, chk_res;
    int          due, busy_n;
  } exp_t;

  exp_t q[$];
  int   vec  = 0;
  int   miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    int   bcnt;
    bcnt = 0;
    forever begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_cycle"}, cyc, e.due);
          chk({e.name, "_busy_cycles"}, bcnt, e.busy_n);
          chk({e.name, "_result_we"}, result_we, e.rwe);
          chk({e.name, "_flags_we"}, flags_we, e.fwe);
          if (e.chk_res) chk({e.name, "_result"}, result, e.res);
          if (e.fwe) chk({e.name, "_flags"}, flags_out, e.flg);
        end
        bcnt = 0;
      end
      if (reset) bcnt = 0;
    end
  end

  // lat = edges from accept to done
  task automatic issue(input string nm, input logic [3:0] o, input logic [15:0] xa,
                       input logic [15:0] xb, input logic [4:0] ps, input logic [15:0] er,
                       input logic [4:0] ef, input logic erwe, input logic efwe, input int lat);
    exp_t e;
    @(negedge clock);
    e.name = nm; e.res = er; e.flg = ef; e.rwe = erwe; e.fwe = efwe;
    e.chk_res = erwe || (o >= 4'd13);
    e.due = cyc + 1 + lat;
    e.busy_n = (lat > 1) ? lat - 1 : 0;
    q.push_back(e);
    start = 1'b1; op = o; a = xa; b = xb; psr_in = ps;
    @(negedge clock);
    // junk operands afterwards: they must not disturb a latched op
    start = 1'b0; op = OP_SUB; a = 16'hDEAD; b = 16'h0001; psr_in = 5'h1F;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; psr_in = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result_we", result_we, 0);
    chk("rst_flags_we", flags_we, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags_out, 0);
    reset = 1'b0;

    issue("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 5'b01100, 16'h8000, 5'b01110, 1, 1, 1); wait_empty();
    issue("cmp_lt",   OP_CMP,  16'h0003, 16'hFFFF, 5'b10010, 16'h0000, 5'b10110, 0, 1, 1); wait_empty();
    issue("cmp_eq",   OP_CMP,  16'h8000, 16'h8000, 5'b00000, 16'h0000, 5'b01000, 0, 1, 1); wait_empty();
    issue("cmp_sgn",  OP_CMP,  16'hFFFF, 16'h0001, 5'b10010, 16'h0000, 5'b10011, 0, 1, 1); wait_empty();
    issue("lsh_l4",   OP_LSH,  16'h0001, 16'h0004, 5'b00000, 16'h0010, 5'b00000, 1, 0, 5); wait_empty();
    issue("lsh_r4",   OP_LSH,  16'h8000, 16'h001C, 5'b00000, 16'h0800, 5'b00000, 1, 0, 5); wait_empty();
    issue("ashu_r4",  OP_ASHU, 16'h8000, 16'h001C, 5'b00000, 16'hF800, 5'b00000, 1, 0, 5); wait_empty();
    issue("ashu_r16", OP_ASHU, 16'h8001, 16'h0010, 5'b00000, 16'hFFFF, 5'b00000, 1, 0, 17); wait_empty();
    issue("lsh_s0",   OP_LSH,  16'h5A5A, 16'h0020, 5'b00000, 16'h5A5A, 5'b00000, 1, 0, 1); wait_empty();
    issue("sub_ovf",  OP_SUB,  16'h8000, 16'h0001, 5'b00000, 16'h7FFF, 5'b00010, 1, 1, 1); wait_empty();
    issue("sub_brw",  OP_SUB,  16'h0001, 16'h0002, 5'b00001, 16'hFFFF, 5'b10001, 1, 1, 1); wait_empty();
    issue("and",      OP_AND,  16'hF0F0, 16'h3C3C, 5'b00000, 16'h3030, 5'b00000, 1, 0, 1); wait_empty();
    issue("or",       OP_OR,   16'hF0F0, 16'h0F01, 5'b00000, 16'hFFF1, 5'b00000, 1, 0, 1); wait_empty();
    issue("xor",      OP_XOR,  16'hFF00, 16'h0FF0, 5'b00000, 16'hF0F0, 5'b00000, 1, 0, 1); wait_empty();
    issue("mov",      OP_MOV,  16'h0000, 16'h1234, 5'b00000, 16'h1234, 5'b00000, 1, 0, 1); wait_empty();
    issue("lui",      OP_LUI,  16'h12CD, 16'h00AB, 5'b00000, 16'hABCD, 5'b00000, 1, 0, 1); wait_empty();
    issue("nop",      4'd13,   16'h1111, 16'h2222, 5'b00000, 16'hABCD, 5'b00000, 0, 0, 1); wait_empty();
    issue("addc",     OP_ADDC, 16'hFFFF, 16'h0000, 5'b10000, 16'h0000, 5'b10000, 1, 1, 1); wait_empty();
    issue("mul_ff",   OP_MUL,  16'hFFFF, 16'hFFFF, 5'b00000, 16'h0001, 5'b00000, 1, 0, 17); wait_empty();

    // MUL with a stray start at T+5 that must be ignored
    issue("mul", OP_MUL, 16'h0123, 16'h0010, 5'b00000, 16'h1230, 5'b00000, 1, 0, 17);
    repeat (3) @(negedge clock);
    start = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
    @(negedge clock);
    start = 1'b0;
    wait_empty();

    // reset at T+8 of a MUL aborts it
    issue("mul_abort", OP_MUL, 16'h0101, 16'h0101, 5'b00000, 16'h0000, 5'b00000, 1, 0, 17);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_result_we", result_we, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    issue("add_after_rst", OP_ADD, 16'h0002, 16'h0003, 5'b00000, 16'h0005, 5'b00000, 1, 1, 1);
    wait_empty();
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
